// File: rtl/fft_pkg.sv
// fft_pkg
// Shared definitions for the iterative FFT sequencing controller:
// FSM state encoding and a constant-evaluable ceil(log2) helper used to
// size counters from the core-level parameters.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } fsm_state_t;

    // Smallest r with 2^r >= v (returns 0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fft_iter_ctrl_if.sv
// fft_iter_ctrl_if
// Host handshake plus datapath-facing strobes/addresses of the FFT
// sequencing controller.
//   master : host / datapath side (drives start, hold)
//   slave  : controller side (drives everything else)
interface fft_iter_ctrl_if #(
    parameter int LOGN = 5
);
    logic            start;
    logic            hold;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [LOGN-1:0] addr_a;
    logic [LOGN-1:0] addr_b;
    logic            we;
    logic [LOGN-1:0] waddr_a;
    logic [LOGN-1:0] waddr_b;
    logic            w_clr;
    logic            w_en;
    logic            w_lay_en;

    modport master (
        output start, hold,
        input  busy, done, rd_en, addr_a, addr_b, we, waddr_a, waddr_b,
               w_clr, w_en, w_lay_en
    );

    modport slave (
        input  start, hold,
        output busy, done, rd_en, addr_a, addr_b, we, waddr_a, waddr_b,
               w_clr, w_en, w_lay_en
    );
endinterface

// File: rtl/fft_wr_delay.sv
// fft_wr_delay
// Fixed-depth shift pipeline that re-times the operand read
// {valid, addr_a, addr_b} into the write-back slot DEPTH cycles later.
//   i_clk, i_rst_n : clock, async active-low reset (flushes the pipe)
//   i_d            : {rd_en, addr_a, addr_b} of the current cycle
//   o_q            : same word delayed by exactly DEPTH cycles
module fft_wr_delay #(
    parameter int W     = 11,
    parameter int DEPTH = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/fft_iter_ctrl.sv
// fft_iter_ctrl
// Sequencer for an in-place iterative radix-2 DIF FFT. Walks LOGN stages
// of N/2 butterflies, issuing operand read addresses, twiddle generator
// strobes and BF_LAT-delayed write-back addresses.
//   i_clk, i_rst_n : clock, async active-low reset
//   ctrl_if        : start/hold in; busy/done, read/write addresses and
//                    strobes, twiddle clear/advance/stage-advance out
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; the accepting edge also issues (s=0,k=0)
//   ST_RUN   | one butterfly per cycle unless hold; last k moves to DRAIN
//   ST_DRAIN | BF_LAT idle cycles so stage writes land before next reads
//   ST_FIN   | raise done for one cycle, back to IDLE
module fft_iter_ctrl
    import fft_pkg::*;
#(
    parameter int LOGN   = 5,
    parameter int BF_LAT = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fft_iter_ctrl_if.slave ctrl_if
);
    localparam int S_W = clog2(LOGN);
    localparam int K_W = LOGN - 1;
    localparam int D_W = clog2(BF_LAT + 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(LOGN - 1);
    localparam logic [K_W-1:0] K_LAST = '1;
    localparam logic [D_W-1:0] D_LOAD = D_W'(BF_LAT - 1);

    fsm_state_t      r_state;
    logic [S_W-1:0]  r_s;
    logic [K_W-1:0]  r_k;
    logic [D_W-1:0]  r_drain_cnt;
    logic            r_rd_en;
    logic [LOGN-1:0] r_addr_a;
    logic [LOGN-1:0] r_addr_b;
    logic            r_w_clr;
    logic            r_w_lay_en;
    logic            r_busy;
    logic            r_done;

    // Insert a 0 at bit p = LOGN-1-s of k: bits below p stay, bits at and
    // above p move up by one. The lower leg is the same address with bit p set.
    logic [S_W-1:0]  w_p;
    logic [LOGN-1:0] w_k_ext;
    logic [LOGN-1:0] w_lo_mask;
    logic [LOGN-1:0] w_addr_a;
    logic [LOGN-1:0] w_addr_b;

    assign w_p       = S_LAST - r_s;
    assign w_k_ext   = {1'b0, r_k};
    assign w_lo_mask = (LOGN'(1) << w_p) - LOGN'(1);
    assign w_addr_a  = ((w_k_ext & ~w_lo_mask) << 1) | (w_k_ext & w_lo_mask);
    assign w_addr_b  = w_addr_a | (LOGN'(1) << w_p);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_k         <= '0;
            r_drain_cnt <= '0;
            r_rd_en     <= 1'b0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_w_clr     <= 1'b0;
            r_w_lay_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rd_en    <= 1'b0;
            r_w_clr    <= 1'b0;
            r_w_lay_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (ctrl_if.start) begin
                        r_state  <= ST_RUN;
                        r_w_clr  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_rd_en  <= 1'b1;
                        r_addr_a <= w_addr_a;
                        r_addr_b <= w_addr_b;
                        r_k      <= r_k + K_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!ctrl_if.hold) begin
                        r_rd_en  <= 1'b1;
                        r_addr_a <= w_addr_a;
                        r_addr_b <= w_addr_b;
                        r_k      <= r_k + K_W'(1);
                        if (r_k == K_LAST) begin
                            r_w_lay_en  <= 1'b1;
                            r_drain_cnt <= D_LOAD;
                            r_state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        if (r_s == S_LAST) begin
                            r_s     <= '0;
                            r_state <= ST_FIN;
                        end else begin
                            r_s     <= r_s + S_W'(1);
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt - D_W'(1);
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    logic [2*LOGN:0] w_wr_in;
    logic [2*LOGN:0] w_wr_out;

    assign w_wr_in = {r_rd_en, r_addr_a, r_addr_b};

    fft_wr_delay #(
        .W     (2*LOGN + 1),
        .DEPTH (BF_LAT)
    ) u_wr_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_wr_in),
        .o_q     (w_wr_out)
    );

    assign ctrl_if.busy     = r_busy;
    assign ctrl_if.done     = r_done;
    assign ctrl_if.rd_en    = r_rd_en;
    assign ctrl_if.addr_a   = r_addr_a;
    assign ctrl_if.addr_b   = r_addr_b;
    assign ctrl_if.w_clr    = r_w_clr;
    assign ctrl_if.w_en     = r_rd_en;
    assign ctrl_if.w_lay_en = r_w_lay_en;
    assign ctrl_if.we       = w_wr_out[2*LOGN];
    assign ctrl_if.waddr_a  = w_wr_out[2*LOGN-1:LOGN];
    assign ctrl_if.waddr_b  = w_wr_out[LOGN-1:0];
endmodule

// File: tb/tb_fft_iter_ctrl.sv
// tb_fft_iter_ctrl
// Directed bench for fft_iter_ctrl: a LOGN=5/BF_LAT=3 instance for frame
// timing, addressing, hold, START handling and reset, plus a
// LOGN=2/BF_LAT=1 instance for the small-transform address sequence.
module tb_fft_iter_ctrl;
    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    fft_iter_ctrl_if #(.LOGN(5)) ifa ();
    fft_iter_ctrl_if #(.LOGN(2)) ifb ();

    fft_iter_ctrl #(.LOGN(5), .BF_LAT(3)) u_dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .ctrl_if (ifa)
    );

    fft_iter_ctrl #(.LOGN(2), .BF_LAT(1)) u_dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .ctrl_if (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference address: build ADDR_A bit by bit, skipping position p.
    function automatic void exp_addr(input int logn, input int s, input int k,
                                     output int a, output int b);
        int p;
        int j;
        p = logn - 1 - s;
        j = 0;
        a = 0;
        for (int i = 0; i < logn; i++) begin
            if (i != p) begin
                a = a | (((k >> j) & 1) << i);
                j++;
            end
        end
        b = a | (1 << p);
    endfunction

    // Write-back must replay the read of 3 cycles earlier (instance A).
    logic       h_v  [3];
    logic [4:0] h_a  [3];
    logic [4:0] h_b  [3];
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                h_v[i] = 1'b0; h_a[i] = '0; h_b[i] = '0;
            end
        end else begin
            check_val("we_delay", ifa.we, h_v[2]);
            if (h_v[2]) begin
                check_val("waddr_a_delay", ifa.waddr_a, h_a[2]);
                check_val("waddr_b_delay", ifa.waddr_b, h_b[2]);
            end
            for (int i = 2; i > 0; i--) begin
                h_v[i] = h_v[i-1]; h_a[i] = h_a[i-1]; h_b[i] = h_b[i-1];
            end
            h_v[0] = ifa.rd_en; h_a[0] = ifa.addr_a; h_b[0] = ifa.addr_b;
        end
    end

    // Observes one frame of instance A. lead = samples before first RD_EN,
    // done_off = samples from first RD_EN to DONE. hold_at > 0 raises HOLD
    // for 4 cycles right after that many issues.
    task automatic run_frame(input bit keep_start, input int hold_at,
                             output int lead, output int done_off);
        int n_rd, n_wen, n_lay, n_clr, n_busy_lo, hold_left, n_we_hold, c0;
        int ea, eb, s, k;
        logic [4:0] last_a;
        bit seen;
        n_rd = 0; n_wen = 0; n_lay = 0; n_clr = 0; n_busy_lo = 0;
        hold_left = 0; n_we_hold = 0; c0 = 0; seen = 0; last_a = '0;
        lead = -1; done_off = -1;
        for (int c = 0; c < 400 && done_off < 0; c++) begin
            @(negedge clk);
            if (!seen && ifa.rd_en) begin
                seen = 1; lead = c; c0 = c;
                check_val("w_clr_first", ifa.w_clr, 1);
                if (!keep_start) ifa.start = 1'b0;
            end
            if (seen) begin
                if (hold_left > 0) begin
                    check_val("hold_rd_en", ifa.rd_en, 0);
                    check_val("hold_addr_a", ifa.addr_a, last_a);
                    if (ifa.we) n_we_hold++;
                    hold_left--;
                    if (hold_left == 0) ifa.hold = 1'b0;
                end
                if (ifa.rd_en) begin
                    s = n_rd / 16; k = n_rd % 16;
                    exp_addr(5, s, k, ea, eb);
                    check_val("addr_a", ifa.addr_a, ea);
                    check_val("addr_b", ifa.addr_b, eb);
                    check_val("lay_en_k15", ifa.w_lay_en, (k == 15) ? 1 : 0);
                    if (n_rd == 1)  begin check_val("s0k1_a", ifa.addr_a, 1);  check_val("s0k1_b", ifa.addr_b, 17); end
                    if (n_rd == 25) begin check_val("s1k9_a", ifa.addr_a, 17); check_val("s1k9_b", ifa.addr_b, 25); end
                    if (n_rd == 65) begin check_val("s4k1_a", ifa.addr_a, 2);  check_val("s4k1_b", ifa.addr_b, 3);  end
                    last_a = ifa.addr_a;
                    n_rd++;
                    if (n_rd == hold_at) begin
                        ifa.hold = 1'b1; hold_left = 4;
                    end
                end
                n_wen += int'(ifa.w_en);
                n_lay += int'(ifa.w_lay_en);
                n_clr += int'(ifa.w_clr);
                if (ifa.done) begin
                    done_off = c - c0;
                    check_val("busy_at_done", ifa.busy, 0);
                end else if (!ifa.busy) begin
                    n_busy_lo++;
                end
            end
        end
        check_val("frame_completed", (done_off >= 0) ? 1 : 0, 1);
        check_val("rd_en_count", n_rd, 80);
        check_val("w_en_count", n_wen, 80);
        check_val("lay_en_count", n_lay, 5);
        check_val("w_clr_count", n_clr, 1);
        check_val("busy_gaps", n_busy_lo, 0);
        if (hold_at > 0) check_val("we_during_hold", n_we_hold, 3);
    endtask

    initial begin
        int lead, d, n, ea_b[4], eb_b[4];
        int ga[4], gb[4], done_b, c0;
        rst_n = 1'b0;
        ifa.start = 1'b0; ifa.hold = 1'b0;
        ifb.start = 1'b0; ifb.hold = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", ifa.busy, 0);
        check_val("rst_rd_en", ifa.rd_en, 0);
        check_val("rst_we", ifa.we, 0);
        check_val("rst_done", ifa.done, 0);
        check_val("rst_w_clr", ifa.w_clr, 0);
        check_val("rst_addr_b", ifa.addr_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain single frame.
        ifa.start = 1'b1;
        run_frame(0, 0, lead, d);
        check_val("f1_lead", lead, 0);
        check_val("f1_done_offset", d, 95);

        // HOLD for 4 cycles during stage 2.
        repeat (2) @(negedge clk);
        ifa.start = 1'b1;
        run_frame(0, 37, lead, d);
        check_val("hold_done_offset", d, 99);

        // START held high: frames back to back, separated only by DONE.
        repeat (2) @(negedge clk);
        ifa.start = 1'b1;
        run_frame(1, 0, lead, d);
        check_val("held_f1_done_offset", d, 95);
        run_frame(0, 0, lead, d);
        check_val("b2b_lead", lead, 0);
        check_val("held_f2_done_offset", d, 95);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n += int'(ifa.rd_en) + int'(ifa.busy);
        end
        check_val("idle_after_start_drop", n, 0);

        // Reset during stage 3.
        ifa.start = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 52; c++) begin
            @(negedge clk);
            if (ifa.rd_en) begin
                n++;
                ifa.start = 1'b0;
            end
        end
        check_val("reached_stage3", n, 52);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", ifa.busy, 0);
        check_val("mid_rst_rd_en", ifa.rd_en, 0);
        check_val("mid_rst_we", ifa.we, 0);
        check_val("mid_rst_addr_a", ifa.addr_a, 0);
        check_val("mid_rst_waddr_a", ifa.waddr_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n += int'(ifa.we) + int'(ifa.rd_en);
        end
        check_val("post_rst_quiet", n, 0);
        ifa.start = 1'b1;
        run_frame(0, 0, lead, d);
        check_val("post_rst_done_offset", d, 95);

        // LOGN=2, BF_LAT=1 instance.
        ea_b[0] = 0; eb_b[0] = 2;
        ea_b[1] = 1; eb_b[1] = 3;
        ea_b[2] = 0; eb_b[2] = 1;
        ea_b[3] = 2; eb_b[3] = 3;
        for (int i = 0; i < 4; i++) begin ga[i] = -1; gb[i] = -1; end
        n = 0; done_b = -1; c0 = -1;
        @(negedge clk);
        ifb.start = 1'b1;
        for (int c = 0; c < 40 && done_b < 0; c++) begin
            @(negedge clk);
            ifb.start = 1'b0;
            if (ifb.rd_en) begin
                if (c0 < 0) c0 = c;
                if (n < 4) begin ga[n] = int'(ifb.addr_a); gb[n] = int'(ifb.addr_b); end
                n++;
            end
            if (ifb.done && c0 >= 0) done_b = c - c0;
        end
        check_val("small_rd_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            check_val("small_addr_a", ga[i], ea_b[i]);
            check_val("small_addr_b", gb[i], eb_b[i]);
        end
        check_val("small_done_offset", done_b, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/fft_iter_ctrl.md
# fft_iter_ctrl

Sequencing controller for the in-place iterative radix-2 DIF FFT core. On a START request it walks all LOGN stages × N/2 butterflies, issuing per-butterfly operand addresses to the data RAM and enable strobes to the twiddle address generator. It also produces delayed write-back addresses and strobes matched to the butterfly pipeline latency. It sits between the host handshake and the datapath (data RAM, butterfly, twiddle address generator).

## Interface
- LOGN, 5, log2 of transform size N (N = 2^LOGN, LOGN ≥ 2)
- BF_LAT, 3, butterfly read-to-write latency in cycles (≥ 1)
- CLK  in  1  single clock, rising edge
- RST  in  1  reset; asynchronous, active-low
- START  in  1  frame request, sampled only in IDLE
- HOLD  in  1  suspends butterfly issue while high (in-flight writes continue)
- BUSY  out  1  frame in progress
- DONE  out  1  one-cycle pulse, frame complete
- RD_EN  out  1  butterfly operand read strobe
- ADDR_A  out  LOGN  upper-leg operand address
- ADDR_B  out  LOGN  lower-leg operand address
- WE  out  1  write-back strobe, RD_EN delayed BF_LAT
- WADDR_A  out  LOGN  ADDR_A delayed BF_LAT
- WADDR_B  out  LOGN  ADDR_B delayed BF_LAT
- W_CLR  out  1  one-cycle synchronous clear to twiddle address generator
- W_EN  out  1  twiddle address advance, equals RD_EN
- W_LAY_EN  out  1  twiddle stage advance

## Operation
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE: START=1 → RUN; W_CLR=1 that cycle; stage s=0, butterfly k=0.
- RUN, HOLD=0: issue butterfly (s,k): RD_EN=W_EN=1; k increments. At k=N/2-1: W_LAY_EN=1, → DRAIN.
- RUN, HOLD=1: no issue; counters, addresses frozen; RD_EN=0.
- DRAIN: BF_LAT cycles with no issue (avoids read-after-write across stages); then s<LOGN-1 → RUN with s+1, k=0; else → FIN.
- FIN: DONE=1 for one cycle → IDLE. START ignored outside IDLE.
- Address rule: p = LOGN-1-s; ADDR_A = k with a 0 inserted at bit p (k bits ≥ p shift up); ADDR_B = ADDR_A | 2^p. k is LOGN-1 bits wide, wraps to 0 at stage end.
- HOLD is ignored in DRAIN/FIN. Write pipeline advances every cycle regardless of HOLD.
- Reset (any time, including mid-frame): state IDLE, s=k=0, write pipeline flushed. All outputs 0.

## Timing
- RD_EN, ADDR_A/B, W_EN, W_LAY_EN, BUSY, DONE, W_CLR are registered outputs.
- START high at edge t0 → W_CLR high in cycle t0+1. First RD_EN (s=0,k=0) in cycle t0+1.
- WE/WADDR_A/WADDR_B equal RD_EN/ADDR_A/ADDR_B from exactly BF_LAT cycles earlier.
- With no HOLD, stage period = N/2 + BF_LAT cycles. First RD_EN of stage s+1 comes one cycle after the last WE of stage s.
- DONE asserts LOGN·(N/2+BF_LAT) cycles after the first RD_EN. BUSY is high from the first RD_EN through the cycle before DONE.
- Each HOLD cycle during RUN extends the frame by exactly one cycle.

## Structure
- Shared package fft_pkg: FSM state encoding and the clog2 helper; LOGN/BF_LAT defaults live with the core-level parameters.
- Sub-module fft_wr_delay: BF_LAT-deep shift pipeline of {valid, addr_a, addr_b}, width 1+2·LOGN, async active-low reset clearing valid.
- Address bit-insertion is combinational logic inside fft_iter_ctrl.

## Test plan
- LOGN=5, BF_LAT=3, single START, HOLD=0: 80 RD_EN; s=0,k=1 → A=1,B=17; s=1,k=9 → A=17,B=25; s=4,k=1 → A=2,B=3. DONE exactly 95 cycles after first RD_EN.
- Same config: every WE/WADDR matches RD_EN/ADDR from 3 cycles earlier. 5 W_LAY_EN pulses, one per stage, coincident with k=15 issues. 80 W_EN pulses. 1 W_CLR pulse.
- HOLD asserted for 4 cycles mid-stage 2 → addresses frozen, no RD_EN, in-flight WE still fire; DONE shifts to cycle 99.
- START held high continuously → exactly one frame per IDLE visit. Back-to-back frames are separated by the DONE cycle. START during BUSY has no effect.
- RST low during stage 3 → all outputs 0 immediately, no further WE; subsequent START runs a full clean frame.
- LOGN=2, BF_LAT=1: stage 0 addresses (0,2),(1,3); stage 1 addresses (0,1),(2,3); DONE 6 cycles after first RD_EN.
